// File: rtl/clock_pkg.sv
// Shared time widths, limits and alarm channel state encoding.
package clock_pkg;
  localparam int HR_W      = 6;
  localparam int MIN_W     = 6;
  localparam int SEC_W     = 6;
  localparam int HR_MAX_24 = 23;
  localparam int MIN_MAX   = 59;

  typedef enum logic [1:0] {
    DISARMED = 2'd0,
    ARMED    = 2'd1,
    RINGING  = 2'd2,
    SNOOZED  = 2'd3
  } alarm_state_t;
endpackage

// File: rtl/alarm_channel.sv
// One alarm channel: programmed hr/min, arm/ring/snooze FSM and its counters.
// Snooze support is compiled in only when ALARM_SNOOZE_EN is defined.
module alarm_channel
  import clock_pkg::*;
#(
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_MIN  = 5,
  parameter int MAX_SNOOZES = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [HR_W-1:0]  curr_hr,
  input  logic [MIN_W-1:0] curr_min,
  input  logic [SEC_W-1:0] curr_sec,
  input  logic             wr_en,
  input  logic [HR_W-1:0]  wr_hr,
  input  logic [MIN_W-1:0] wr_min,
  input  logic             wr_arm,
  input  logic             ack,
  input  logic             snooze,
  output logic             ringing,
  output logic             snoozed
);
  localparam int RC_W = $clog2(RING_SECS + 1);
  localparam logic [RC_W-1:0] RING_LOAD = RC_W'(RING_SECS);

  alarm_state_t     state_r, state_s;
  logic [HR_W-1:0]  hr_r;
  logic [MIN_W-1:0] min_r;
  logic [RC_W-1:0]  ring_cnt_r, ring_cnt_s;
  logic             ringing_r, snoozed_r;
  logic             trigger_s;

`ifdef ALARM_SNOOZE_EN
  localparam int SC_W = $clog2(SNOOZE_MIN * 60 + 1);
  localparam int SN_W = $clog2(MAX_SNOOZES + 1);
  localparam logic [SC_W-1:0] SNZ_LOAD = SC_W'(SNOOZE_MIN * 60);
  logic [SC_W-1:0] snz_cnt_r, snz_cnt_s;
  logic [SN_W-1:0] snz_num_r, snz_num_s;
`else
  logic unused_cfg_s;
  assign unused_cfg_s = snooze ^ (SNOOZE_MIN == 0) ^ (MAX_SNOOZES == 0);
`endif

  assign trigger_s = (state_r == ARMED) && (hr_r == curr_hr) && (min_r == curr_min)
                     && (curr_sec == {SEC_W{1'b0}});
  assign ringing   = ringing_r;
  assign snoozed   = snoozed_r;

  // Next-state: write > ack > snooze > timeout/snooze expiry > trigger.
  always_comb begin
    state_s    = state_r;
    ring_cnt_s = ring_cnt_r;
`ifdef ALARM_SNOOZE_EN
    snz_cnt_s  = snz_cnt_r;
    snz_num_s  = snz_num_r;
`endif
    if (wr_en) begin
      state_s    = wr_arm ? ARMED : DISARMED;
      ring_cnt_s = {RC_W{1'b0}};
`ifdef ALARM_SNOOZE_EN
      snz_cnt_s  = {SC_W{1'b0}};
      snz_num_s  = {SN_W{1'b0}};
`endif
    end else begin
      case (state_r)
        RINGING: begin
          if (ack) begin
            state_s    = ARMED;
            ring_cnt_s = {RC_W{1'b0}};
          end
`ifdef ALARM_SNOOZE_EN
          else if (snooze) begin
            ring_cnt_s = {RC_W{1'b0}};
            if (snz_num_r < SN_W'(MAX_SNOOZES)) begin
              state_s   = SNOOZED;
              snz_cnt_s = SNZ_LOAD;
              snz_num_s = snz_num_r + SN_W'(1);
            end else begin
              state_s = ARMED;
            end
          end
`endif
          else if (ring_cnt_r <= RC_W'(1)) begin
            state_s    = ARMED;
            ring_cnt_s = {RC_W{1'b0}};
          end else begin
            ring_cnt_s = ring_cnt_r - RC_W'(1);
          end
        end
`ifdef ALARM_SNOOZE_EN
        SNOOZED: begin
          if (ack) begin
            state_s   = ARMED;
            snz_cnt_s = {SC_W{1'b0}};
          end else if (snz_cnt_r <= SC_W'(1)) begin
            state_s    = RINGING;
            ring_cnt_s = RING_LOAD;
            snz_cnt_s  = {SC_W{1'b0}};
          end else begin
            snz_cnt_s = snz_cnt_r - SC_W'(1);
          end
        end
`endif
        ARMED: begin
          if (trigger_s) begin
            state_s    = RINGING;
            ring_cnt_s = RING_LOAD;
`ifdef ALARM_SNOOZE_EN
            snz_num_s  = {SN_W{1'b0}};
`endif
          end else begin
            state_s = ARMED;
          end
        end
        DISARMED: state_s = DISARMED;
        default:  state_s = DISARMED;
      endcase
    end
  end

  // State, programmed time, counters and registered status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= DISARMED;
      hr_r       <= {HR_W{1'b0}};
      min_r      <= {MIN_W{1'b0}};
      ring_cnt_r <= {RC_W{1'b0}};
      ringing_r  <= 1'b0;
      snoozed_r  <= 1'b0;
`ifdef ALARM_SNOOZE_EN
      snz_cnt_r  <= {SC_W{1'b0}};
      snz_num_r  <= {SN_W{1'b0}};
`endif
    end else begin
      state_r    <= state_s;
      ring_cnt_r <= ring_cnt_s;
      ringing_r  <= (state_s == RINGING);
      snoozed_r  <= (state_s == SNOOZED);
      if (wr_en) begin
        hr_r  <= wr_hr;
        min_r <= wr_min;
      end
`ifdef ALARM_SNOOZE_EN
      snz_cnt_r  <= snz_cnt_s;
      snz_num_r  <= snz_num_s;
`endif
    end
  end
endmodule

// File: rtl/alarm_bank.sv
// Multi-channel alarm unit: write validation/decode, merged buzzer and
// lowest-index ringing channel encoder. Snooze gated by ALARM_SNOOZE_EN.
module alarm_bank
  import clock_pkg::*;
#(
  parameter int NUM_ALARMS  = 4,
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_MIN  = 5,
  parameter int MAX_SNOOZES = 3,
  localparam int IDX_W = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [HR_W-1:0]       curr_hr,
  input  logic [MIN_W-1:0]      curr_min,
  input  logic [SEC_W-1:0]      curr_sec,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [HR_W-1:0]       wr_hr,
  input  logic [MIN_W-1:0]      wr_min,
  input  logic                  wr_arm,
  input  logic                  ack,
  input  logic                  snooze,
  output logic [NUM_ALARMS-1:0] ring_vec,
  output logic [NUM_ALARMS-1:0] snoozed_vec,
  output logic                  buzzer,
  output logic                  active_valid,
  output logic [IDX_W-1:0]      active_idx,
  output logic                  wr_err
);
  logic wr_ok_s;

  assign wr_ok_s = (wr_hr <= HR_W'(HR_MAX_24)) && (wr_min <= MIN_W'(MIN_MAX))
                   && (int'(wr_idx) < NUM_ALARMS);

  for (genvar i = 0; i < NUM_ALARMS; i++) begin : g_ch
    alarm_channel #(
      .RING_SECS  (RING_SECS),
      .SNOOZE_MIN (SNOOZE_MIN),
      .MAX_SNOOZES(MAX_SNOOZES)
    ) u_ch (
      .clk     (clk),
      .reset   (reset),
      .curr_hr (curr_hr),
      .curr_min(curr_min),
      .curr_sec(curr_sec),
      .wr_en   (wr_en && wr_ok_s && (wr_idx == IDX_W'(i))),
      .wr_hr   (wr_hr),
      .wr_min  (wr_min),
      .wr_arm  (wr_arm),
      .ack     (ack),
      .snooze  (snooze),
      .ringing (ring_vec[i]),
      .snoozed (snoozed_vec[i])
    );
  end

  assign buzzer       = |ring_vec;
  assign active_valid = |ring_vec;

  // Lowest-index ringing channel; scanning downward lets the lowest win.
  always_comb begin
    active_idx = {IDX_W{1'b0}};
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (ring_vec[i]) begin
        active_idx = IDX_W'(i);
      end else begin
        active_idx = active_idx;
      end
    end
  end

  // One-cycle pulse for a rejected write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_err <= 1'b0;
    end else begin
      wr_err <= wr_en && !wr_ok_s;
    end
  end
endmodule

// File: tb/tb_alarm_bank.sv
// Directed self-checking bench for alarm_bank (defaults: 4 channels, 60 s ring,
// 5 min snooze, 3 snoozes). Snooze scenarios follow ALARM_SNOOZE_EN.
module tb_alarm_bank;
  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] curr_hr, curr_min, curr_sec;
  logic       wr_en;
  logic [1:0] wr_idx;
  logic [5:0] wr_hr, wr_min;
  logic       wr_arm, ack, snooze;
  logic [3:0] ring_vec, snoozed_vec;
  logic       buzzer, active_valid, wr_err;
  logic [1:0] active_idx;

  int vecs = 0;
  int errs = 0;

  alarm_bank dut (
    .clk(clk), .reset(reset), .curr_hr(curr_hr), .curr_min(curr_min), .curr_sec(curr_sec),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_hr(wr_hr), .wr_min(wr_min), .wr_arm(wr_arm),
    .ack(ack), .snooze(snooze), .ring_vec(ring_vec), .snoozed_vec(snoozed_vec),
    .buzzer(buzzer), .active_valid(active_valid), .active_idx(active_idx), .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_time(input int h, input int m, input int s);
    curr_hr  = 6'(h);
    curr_min = 6'(m);
    curr_sec = 6'(s);
  endtask

  task automatic write(input int idx, input int h, input int m, input logic arm);
    wr_en  = 1'b1;
    wr_idx = 2'(idx);
    wr_hr  = 6'(h);
    wr_min = 6'(m);
    wr_arm = arm;
    step();
    wr_en  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    vecs++;
    if ({ring_vec, snoozed_vec, buzzer, active_valid, active_idx, wr_err} !== 13'd0) begin
      errs++;
      $display("FAIL reset_outputs: got ring=%b snz=%b buz=%b av=%b idx=%0d err=%b want all 0",
               ring_vec, snoozed_vec, buzzer, active_valid, active_idx, wr_err);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_trigger();
    write(0, 7, 30, 1'b1);
    set_time(7, 29, 59);
    step();
    vecs++;
    if (ring_vec !== 4'b0000) begin errs++; $display("FAIL pre_trigger: got %b want 0000", ring_vec); end
    set_time(7, 30, 0);
    step();
    set_time(7, 30, 1);
    vecs++;
    if ({ring_vec, buzzer, active_valid, active_idx} !== {4'b0001, 1'b1, 1'b1, 2'd0}) begin
      errs++;
      $display("FAIL trigger: got ring=%b buz=%b av=%b idx=%0d want 0001 1 1 0",
               ring_vec, buzzer, active_valid, active_idx);
    end
  endtask

  task automatic test_timeout();
    for (int i = 1; i < 60; i++) step();
    vecs++;
    if (ring_vec !== 4'b0001) begin errs++; $display("FAIL ring_cycle60: got %b want 0001", ring_vec); end
    step();
    vecs++;
    if ({ring_vec, buzzer} !== 5'b00000) begin
      errs++; $display("FAIL ring_timeout: got ring=%b buz=%b want 0000 0", ring_vec, buzzer);
    end
    set_time(7, 30, 0);
    step();
    set_time(7, 30, 1);
    vecs++;
    if (ring_vec !== 4'b0001) begin errs++; $display("FAIL next_day_refire: got %b want 0001", ring_vec); end
    ack = 1'b1;
    step();
    ack = 1'b0;
    vecs++;
    if (ring_vec !== 4'b0000) begin errs++; $display("FAIL ack_single: got %b want 0000", ring_vec); end
  endtask

  task automatic test_snooze();
    write(2, 8, 0, 1'b1);
    set_time(8, 0, 0);
    step();
    set_time(8, 0, 1);
    vecs++;
    if ({ring_vec, active_idx} !== {4'b0100, 2'd2}) begin
      errs++; $display("FAIL ch2_trigger: got ring=%b idx=%0d want 0100 2", ring_vec, active_idx);
    end
`ifdef ALARM_SNOOZE_EN
    for (int k = 1; k <= 3; k++) begin
      snooze = 1'b1;
      step();
      snooze = 1'b0;
      vecs++;
      if ({ring_vec, snoozed_vec} !== {4'b0000, 4'b0100}) begin
        errs++; $display("FAIL snooze%0d_enter: got ring=%b snz=%b want 0000 0100", k, ring_vec, snoozed_vec);
      end
      for (int i = 1; i < 300; i++) begin
        snooze = (i == 100);
        step();
      end
      snooze = 1'b0;
      vecs++;
      if ({ring_vec, snoozed_vec} !== {4'b0000, 4'b0100}) begin
        errs++; $display("FAIL snooze%0d_hold299: got ring=%b snz=%b want 0000 0100", k, ring_vec, snoozed_vec);
      end
      step();
      vecs++;
      if ({ring_vec, snoozed_vec} !== {4'b0100, 4'b0000}) begin
        errs++; $display("FAIL snooze%0d_rering: got ring=%b snz=%b want 0100 0000", k, ring_vec, snoozed_vec);
      end
    end
    snooze = 1'b1;
    step();
    snooze = 1'b0;
    vecs++;
    if ({ring_vec, snoozed_vec} !== 8'h00) begin
      errs++; $display("FAIL snooze4_to_armed: got ring=%b snz=%b want 0000 0000", ring_vec, snoozed_vec);
    end
`else
    snooze = 1'b1;
    step();
    snooze = 1'b0;
    vecs++;
    if ({ring_vec, snoozed_vec} !== {4'b0100, 4'b0000}) begin
      errs++; $display("FAIL snooze_ignored: got ring=%b snz=%b want 0100 0000", ring_vec, snoozed_vec);
    end
    ack = 1'b1;
    step();
    ack = 1'b0;
`endif
    vecs++;
    if (ring_vec !== 4'b0000) begin errs++; $display("FAIL ch2_quiet: got %b want 0000", ring_vec); end
  endtask

  task automatic test_multi();
    write(1, 12, 0, 1'b1);
    write(3, 12, 0, 1'b1);
    set_time(12, 0, 0);
    step();
    set_time(12, 0, 1);
    vecs++;
    if ({ring_vec, active_valid, active_idx} !== {4'b1010, 1'b1, 2'd1}) begin
      errs++; $display("FAIL multi_ring: got ring=%b av=%b idx=%0d want 1010 1 1", ring_vec, active_valid, active_idx);
    end
    ack = 1'b1;
    step();
    ack = 1'b0;
    vecs++;
    if ({ring_vec, buzzer} !== 5'b00000) begin
      errs++; $display("FAIL multi_ack: got ring=%b buz=%b want 0000 0", ring_vec, buzzer);
    end
    set_time(12, 0, 0);
    step();
    set_time(12, 0, 1);
    ack = 1'b1;
    snooze = 1'b1;
    step();
    ack = 1'b0;
    snooze = 1'b0;
    vecs++;
    if ({ring_vec, snoozed_vec} !== 8'h00) begin
      errs++; $display("FAIL ack_snooze_both: got ring=%b snz=%b want 0000 0000", ring_vec, snoozed_vec);
    end
  endtask

  task automatic test_write();
    set_time(7, 29, 59);
    write(0, 24, 30, 1'b1);
    vecs++;
    if (wr_err !== 1'b1) begin errs++; $display("FAIL wr_err_hr24: got %b want 1", wr_err); end
    step();
    vecs++;
    if (wr_err !== 1'b0) begin errs++; $display("FAIL wr_err_pulse: got %b want 0", wr_err); end
    set_time(7, 30, 0);
    step();
    set_time(7, 30, 1);
    vecs++;
    if (ring_vec !== 4'b0001) begin errs++; $display("FAIL rejected_unchanged: got %b want 0001", ring_vec); end
    write(0, 7, 60, 1'b0);
    vecs++;
    if ({wr_err, ring_vec} !== 5'b10001) begin
      errs++; $display("FAIL wr_err_min60: got err=%b ring=%b want 1 0001", wr_err, ring_vec);
    end
    write(0, 7, 30, 1'b0);
    vecs++;
    if ({wr_err, ring_vec} !== 5'b00000) begin
      errs++; $display("FAIL write_disarm_ringing: got err=%b ring=%b want 0 0000", wr_err, ring_vec);
    end
    set_time(7, 30, 0);
    step();
    vecs++;
    if (ring_vec !== 4'b0000) begin errs++; $display("FAIL disarmed_no_ring: got %b want 0000", ring_vec); end
    write(0, 7, 30, 1'b1);
    vecs++;
    if (ring_vec !== 4'b0000) begin errs++; $display("FAIL write_at_match: got %b want 0000", ring_vec); end
    step();
    set_time(7, 30, 1);
    vecs++;
    if (ring_vec !== 4'b0001) begin errs++; $display("FAIL next_match_after_write: got %b want 0001", ring_vec); end
  endtask

  task automatic test_reset_ring();
    #2 reset = 1'b1;
    #1;
    vecs++;
    if ({ring_vec, snoozed_vec, buzzer, active_valid, active_idx, wr_err} !== 13'd0) begin
      errs++; $display("FAIL async_reset: got ring=%b buz=%b av=%b idx=%0d want all 0",
                       ring_vec, buzzer, active_valid, active_idx);
    end
    step();
    reset = 1'b0;
    step();
    set_time(7, 30, 0);
    step();
    set_time(12, 0, 0);
    step();
    set_time(12, 0, 1);
    vecs++;
    if ({ring_vec, buzzer} !== 5'b00000) begin
      errs++; $display("FAIL post_reset_disarmed: got ring=%b buz=%b want 0000 0", ring_vec, buzzer);
    end
  endtask

  initial begin
    reset = 1'b1;
    wr_en = 1'b0; wr_idx = 2'd0; wr_hr = 6'd0; wr_min = 6'd0; wr_arm = 1'b0;
    ack = 1'b0; snooze = 1'b0;
    set_time(0, 0, 1);
    test_reset();
    test_trigger();
    test_timeout();
    test_snooze();
    test_multi();
    test_write();
    test_reset_ring();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/alarm_bank.md
# alarm_bank

Parametrised multi-channel alarm unit, the next generation of the single-alarm comparator. It holds NUM_ALARMS independently programmable alarms (hour/minute, arm state). Each alarm rings for a bounded time and can be acknowledged or snoozed. It sits beside the timekeeper and consumes its 24-hour hr/min/sec outputs. It drives a merged buzzer plus per-channel status to the top-level mode FSM.

## Interface
Parameters:
- NUM_ALARMS, 4 — number of alarm channels (1..16)
- RING_SECS, 60 — cycles a channel rings before auto-timeout (≥1)
- SNOOZE_MIN, 5 — snooze length in minutes (1..30)
- MAX_SNOOZES, 3 — snoozes allowed per trigger; a further snooze acts as ack

Ports (one clock, clk; reset is asynchronous and active-high, named reset):
- clk  in  1  system clock, one cycle = one second
- reset  in  1  asynchronous, active-high
- curr_hr  in  6  current hour, 24-hour format 0..23
- curr_min  in  6  current minute 0..59
- curr_sec  in  6  current second 0..59
- wr_en  in  1  program a channel this cycle
- wr_idx  in  $clog2(NUM_ALARMS)  channel being programmed
- wr_hr  in  6  alarm hour 0..23
- wr_min  in  6  alarm minute 0..59
- wr_arm  in  1  1 = ARMED after write, 0 = DISARMED
- ack  in  1  stop all ringing channels
- snooze  in  1  snooze all ringing channels
- ring_vec  out  NUM_ALARMS  per-channel ringing
- snoozed_vec  out  NUM_ALARMS  per-channel snoozed
- buzzer  out  1  OR of ring_vec
- active_valid  out  1  any channel ringing
- active_idx  out  $clog2(NUM_ALARMS)  lowest-index ringing channel, 0 when none
- wr_err  out  1  one-cycle pulse on a rejected write

## Operation
- Per-channel FSM states: DISARMED, ARMED, RINGING, SNOOZED.
- Reset state: all channels DISARMED, hr=0, min=0, counters 0. All outputs are 0.
- Trigger: an ARMED channel whose hr/min equal curr_hr/curr_min while curr_sec==0 goes to RINGING. Its ring counter loads RING_SECS and its snooze count clears.
- RINGING transitions:
  - ack → ARMED; the alarm re-fires the next day.
  - snooze with snooze count < MAX_SNOOZES → SNOOZED. The snooze counter loads SNOOZE_MIN*60 and the snooze count increments.
  - snooze with snooze count == MAX_SNOOZES → ARMED.
  - Ring counter reaching 1 with no input → ARMED (timeout).
- SNOOZED: the snooze counter decrements each cycle. On reaching 1 → RINGING and the ring counter reloads. ack in SNOOZED → ARMED. snooze in SNOOZED is ignored.
- ack and snooze act on every channel in the relevant state simultaneously.
- Write:
  - Accepted only if wr_hr≤23, wr_min≤59 and wr_idx<NUM_ALARMS.
  - An accepted write replaces hr/min, sets the state per wr_arm and clears that channel's counters, cancelling any ring or snooze.
  - A rejected write leaves all state unchanged and pulses wr_err.
- Per-channel priority: write > ack > snooze > timeout/snooze-expiry > trigger.
- A trigger match while RINGING or SNOOZED is ignored.
- ack and snooze asserted together: ack wins.

## Timing
- State and counters are registered. ring_vec, snoozed_vec and wr_err are registered.
- buzzer, active_valid and active_idx are combinational from the registered state, valid in the same cycle as ring_vec.
- Trigger latency: match sampled at cycle t (curr_sec==0) → ring_vec bit high from t+1.
- Ring duration: with no ack, ring_vec stays high exactly RING_SECS cycles.
- Snooze: ring_vec low from the cycle after snooze. It re-asserts SNOOZE_MIN*60 cycles after snoozed_vec rises.
- Write latency: the write takes effect on the next edge.
  - A write to a channel's current time with wr_arm=1 while curr_sec==0 does not trigger in that cycle.
  - The channel triggers on the next matching day.
- Reset mid-ring clears buzzer asynchronously.
- Counter widths: $clog2(SNOOZE_MIN*60+1) and $clog2(RING_SECS+1) bits, with no wrap in range.

## Configuration
- ALARM_SNOOZE_EN defined: full snooze behaviour as above.
- ALARM_SNOOZE_EN undefined:
  - snooze input ignored; SNOOZED unreachable.
  - snooze counters and snooze count removed.
  - snoozed_vec tied 0.
  - All ports are retained.

## Structure
- Shared package clock_pkg:
  - time widths (HR_W=6, MIN_W=6, SEC_W=6)
  - HR_MAX_24=23, MIN_MAX=59
  - enum alarm_state_t {DISARMED, ARMED, RINGING, SNOOZED}
- Sub-module alarm_channel: one per channel via generate. It holds the FSM, hr/min registers and counters.
- Top level: write decode/validation, OR-reduce and lowest-index priority encoder.

## Test plan
- Reset, write ch0=07:30 armed; drive time 07:29:59→07:30:00 → ring_vec[0]=1 and buzzer=1 one cycle after 07:30:00; active_idx=0.
- No ack with RING_SECS=60 → ring_vec[0] high exactly 60 cycles, then state ARMED; same time next day re-fires.
- Ringing ch2 with SNOOZE_MIN=5 (ALARM_SNOOZE_EN):
  - snooze → ring low next cycle, snoozed_vec[2]=1;
  - re-rings after 300 cycles;
  - fourth snooze with MAX_SNOOZES=3 → ARMED.
- ch1 and ch3 both =12:00 armed → both ring together; active_idx=1; one ack clears both; ack+snooze together → ack behaviour.
- Write wr_hr=24 or wr_min=60 → wr_err pulse, channel unchanged; write to a ringing channel with wr_arm=0 → ring stops, DISARMED.
- Assert reset while ringing → all outputs 0 immediately; no ring after release at matching time until reprogrammed.
